// File: rtl/sample_frame_buffer.sv
// Ping-pong frame capture buffer: fills two alternating RAM banks with frames of
// 2**ADDR_W samples and hands each full bank to a consumer. Optional macro: SFB_DROP_COUNT_EN.
module sample_frame_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_dv,
  input  logic [DATA_W-1:0] in_data,
  output logic              frame_ready,
  output logic              frame_bank,
  input  logic              frame_release,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              overflow,
  input  logic              ovf_clr,
`ifdef SFB_DROP_COUNT_EN
  output logic [15:0]       drop_count,
`endif
  output logic              wr_wait
);

  typedef enum logic {S_FILL = 1'b0, S_WAIT = 1'b1} wr_state_t;

  wr_state_t         state;
  logic [1:0]        full;
  logic              wbank;
  logic              rbank;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

  logic              rel;
  logic [1:0]        full_rel;
  logic              wr;
  logic              wr_last;
  logic              drop;

  // Release is applied before the writer looks at the bank flags, so a release
  // landing on the last write of the other bank keeps the writer in FILL.
  always_comb begin
    rel      = frame_release & full[rbank];
    full_rel = full;
    if (rel) full_rel[rbank] = 1'b0;
    wr       = (state == S_FILL) & in_dv;
    wr_last  = wr & (waddr == {ADDR_W{1'b1}});
    drop     = (state == S_WAIT) & in_dv;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_FILL;
      full     <= 2'b00;
      wbank    <= 1'b0;
      rbank    <= 1'b0;
      waddr    <= '0;
      overflow <= 1'b0;
`ifdef SFB_DROP_COUNT_EN
      drop_count <= 16'd0;
`endif
    end else begin
      if (rel) rbank <= ~rbank;
      full <= full_rel | (wr_last ? (2'b01 << wbank) : 2'b00);
      case (state)
        S_FILL: begin
          if (wr) begin
            waddr <= waddr + 1'b1;
            if (wr_last) begin
              wbank <= ~wbank;
              if (full_rel[~wbank]) state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A strobe in the releasing cycle is still dropped; writing resumes next strobe.
          if (!full_rel[wbank]) begin
            state <= S_FILL;
            waddr <= '0;
          end
        end
        default: state <= S_FILL;
      endcase
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
`ifdef SFB_DROP_COUNT_EN
      if (drop) begin
        if (ovf_clr) drop_count <= 16'd1;
        else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else if (ovf_clr) begin
        drop_count <= 16'd0;
      end
`endif
    end
  end

  // Sample RAM carries no reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr) mem[{wbank, waddr}] <= in_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rd_data <= '0;
    else if (rd_en) rd_data <= mem[{rbank, rd_addr}];
  end

  assign frame_ready = full[rbank];
  assign frame_bank  = rbank;
  assign wr_wait     = (state == S_WAIT);

endmodule
